// File: rtl/barrel_rotator.sv
// Registered barrel rotator: cyclically rotates a WIDTH-bit word left or
// right by 0..WIDTH-1 positions through a log2(WIDTH)-stage network, with
// the result registered for a single clock of latency.
module barrel_rotator #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [SHW-1:0]   R,
  input  logic             D,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid
);

  // Fixed-distance rotate used by each stage; amt is always 1..WIDTH/2,
  // so both shift counts stay strictly inside the word.
  function automatic logic [WIDTH-1:0] rot_fixed(input logic [WIDTH-1:0] v,
                                                 input int unsigned     amt,
                                                 input logic            dir);
    logic [WIDTH-1:0] r;
    if (dir) r = (v >> amt) | (v << (WIDTH - amt));
    else     r = (v << amt) | (v >> (WIDTH - amt));
    return r;
  endfunction

  logic [WIDTH-1:0] stg [SHW+1];
  logic [WIDTH-1:0] y_d, y_q;
  logic             vld_d, vld_q;

  assign stg[0] = X;

  // Stage k rotates by 2^k when R[k] is set; direction is shared by all stages.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    assign stg[k+1] = R[k] ? rot_fixed(stg[k], 2**k, D) : stg[k];
  end

  // Next state: capture the network output on a valid sample, otherwise hold.
  always_comb begin
    y_d   = y_q;
    vld_d = in_valid;
    if (in_valid) y_d = stg[SHW];
  end

  // Output register; reset wins over any sample presented in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_barrel_rotator.sv
// Self-checking bench for barrel_rotator: directed vector table, reset
// sequences, streaming, exhaustive sweep and random traffic against a
// bit-index reference model.
module tb_barrel_rotator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] X;
  logic [2:0]   R;
  logic         D;
  logic [W-1:0] Y;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  barrel_rotator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .R(R), .D(D),
    .Y(Y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: each output bit picks its source index with modular arithmetic.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x,
                                           input int r, input logic d);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) begin
      int src;
      if (d) src = (i + r) % W;
      else   src = (i - r + W) % W;
      y[i] = x[src];
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [2:0] r, input logic d);
    @(negedge clk);
    in_valid = v; X = x; R = r; D = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [2:0]   r;
    logic         d;
    logic [W-1:0] y;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [W-1:0] last_y;
    logic [W-1:0] exp_y;
    logic         exp_v;

    tbl[0]  = '{8'b10111101, 3'd3, 1'b0, 8'b11101101};
    tbl[1]  = '{8'b10111101, 3'd3, 1'b1, 8'b10110111};
    tbl[2]  = '{8'b10111101, 3'd7, 1'b0, 8'b11011110};
    tbl[3]  = '{8'b10111101, 3'd7, 1'b1, 8'b01111011};
    tbl[4]  = '{8'hA5,       3'd0, 1'b0, 8'hA5};
    tbl[5]  = '{8'hA5,       3'd0, 1'b1, 8'hA5};
    tbl[6]  = '{8'h96,       3'd5, 1'b0, 8'hD2};
    tbl[7]  = '{8'h96,       3'd3, 1'b1, 8'hD2};
    tbl[8]  = '{8'h00,       3'd5, 1'b0, 8'h00};
    tbl[9]  = '{8'hFF,       3'd6, 1'b1, 8'hFF};
    tbl[10] = '{8'h01,       3'd1, 1'b1, 8'h80};
    tbl[11] = '{8'h80,       3'd1, 1'b0, 8'h01};

    // Reset held with a valid all-ones sample presented.
    rst = 1'b1; in_valid = 1'b1; X = 8'hFF; R = 3'd2; D = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_Y", Y, 8'h00);
    chk("reset_vld", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].x, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_Y", i), Y, tbl[i].y);
      chk($sformatf("vec%0d_vld", i), {7'b0, out_valid}, 8'h01);
    end

    // Idle cycle: out_valid drops, Y holds.
    last_y = Y;
    drive(1'b0, 8'h3C, 3'd1, 1'b0);
    chk("idle_vld", {7'b0, out_valid}, 8'h00);
    chk("idle_hold", Y, last_y);

    // Four back-to-back samples, then an idle cycle.
    begin
      logic [W-1:0] sx [4] = '{8'h12, 8'hC3, 8'h5A, 8'hE1};
      logic [2:0]   sr [4] = '{3'd1, 3'd4, 3'd6, 3'd2};
      logic         sd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, sx[i], sr[i], sd[i]);
        chk($sformatf("stream%0d_Y", i), Y, ref_rot(sx[i], int'(sr[i]), sd[i]));
        chk($sformatf("stream%0d_vld", i), {7'b0, out_valid}, 8'h01);
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      chk("stream_idle_vld", {7'b0, out_valid}, 8'h00);
      chk("stream_idle_hold", Y, ref_rot(sx[3], int'(sr[3]), sd[3]));
    end

    // Asynchronous reset mid-cycle clears Y without a clock edge.
    drive(1'b1, 8'h5B, 3'd3, 1'b0);
    chk("pre_async_Y", Y, ref_rot(8'h5B, 3, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_Y", Y, 8'h00);
    chk("async_vld", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Sample presented in the cycle reset asserts is discarded.
    drive(1'b1, 8'h77, 3'd1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; X = 8'hF0; R = 3'd2; D = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_discard_Y", Y, 8'h00);
    chk("rst_discard_vld", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Exhaustive sweep of X, R and D, back-to-back.
    for (int x = 0; x < 256; x++)
      for (int r = 0; r < W; r++)
        for (int d = 0; d < 2; d++) begin
          drive(1'b1, x[W-1:0], r[2:0], d[0]);
          chk($sformatf("sweep_x%0h_r%0d_d%0d", x, r, d), Y, ref_rot(x[W-1:0], r, d[0]));
        end

    // Random traffic with random gaps; the model tracks held value and valid.
    exp_y = Y;
    for (int n = 0; n < 400; n++) begin
      logic         v;
      logic [W-1:0] x;
      logic [2:0]   r;
      logic         d;
      v = ($urandom % 4) != 0;
      x = W'($urandom);
      r = 3'($urandom);
      d = 1'($urandom);
      drive(v, x, r, d);
      if (v) exp_y = ref_rot(x, int'(r), d);
      exp_v = v;
      chk($sformatf("rand%0d_Y", n), Y, exp_y);
      chk($sformatf("rand%0d_vld", n), {7'b0, out_valid}, {7'b0, exp_v});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
